// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
   localparam int WORD_BITS      = BYTES_PER_WORD * 8;

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_WRITE   = 3'd2,
      S_CHECK   = 3'd3,
      S_DONE    = 3'd4
   } loaderState_e;
`else
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_WRITE   = 3'd2,
      S_DONE    = 3'd4
   } loaderState_e;
`endif

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word assembler: holds the first three bytes of a word and
// presents the full word combinationally together with the fourth byte.
module imem_word_assembler
   import imem_loader_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 accept_i,
   input  logic [7:0]           byte_i,
   output logic [WORD_BITS-1:0] word_o,
   output logic                 complete_o
);

   logic [WORD_BITS-9:0]  shift_q, shift_d;
   logic [BYTE_CNT_W-1:0] count_q, count_d;

   // Stalls (accept_i low) leave both the partial word and the count untouched.
   always_comb begin
      shift_d = shift_q;
      count_d = count_q;
      if (clear_i) begin
         shift_d = '0;
         count_d = '0;
      end else if (accept_i) begin
         shift_d = {shift_q[WORD_BITS-17:0], byte_i};
         count_d = count_q + BYTE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q <= '0;
         count_q <= '0;
      end else begin
         shift_q <= shift_d;
         count_q <= count_d;
      end
   end

   assign complete_o = accept_i && !clear_i &&
                       (count_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
   assign word_o     = {shift_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory one word at a time.
// Define IMEM_LOADER_CHECKSUM_EN to verify a trailing XOR checksum word.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MEM_WIDTH     = 32,
   parameter int MEM_DEPTH     = 100,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [$clog2(MEM_DEPTH):0]    num_words,
   input  logic [7:0]                    byte_in,
   input  logic                          byte_valid,
   output logic                          byte_ready,
   output logic                          WE,
   output logic [ADDRESS_WIDTH-1:0]      WA,
   output logic [MEM_WIDTH-1:0]          WD,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int NW_W = $clog2(MEM_DEPTH) + 1;

   loaderState_e           state_q;
   logic [NW_W-1:0]        numWords_q;
   logic [NW_W-1:0]        wordIdx_q;
   logic                   byteReady_q;
   logic                   we_q;
   logic [ADDRESS_WIDTH-1:0] wa_q;
   logic [MEM_WIDTH-1:0]   wd_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_BITS-1:0]   csum_q;
`endif

   logic                   asmClear;
   logic                   asmAccept;
   logic                   asmComplete;
   logic [WORD_BITS-1:0]   asmWord;

   assign asmClear  = (state_q == S_IDLE) && start;
   assign asmAccept = byte_valid && byteReady_q;

   imem_word_assembler u_assembler (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (asmClear),
      .accept_i   (asmAccept),
      .byte_i     (byte_in),
      .word_o     (asmWord),
      .complete_o (asmComplete)
   );

   // Every output is registered and updated alongside the state transition that implies it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         numWords_q  <= '0;
         wordIdx_q   <= '0;
         byteReady_q <= 1'b0;
         we_q        <= 1'b0;
         wa_q        <= '0;
         wd_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  numWords_q <= num_words;
                  wordIdx_q  <= '0;
                  err_q      <= 1'b0;
                  busy_q     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q     <= '0;
`endif
                  if (num_words == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else if (int'(num_words) > MEM_DEPTH) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else begin
                     state_q     <= S_COLLECT;
                     byteReady_q <= 1'b1;
                  end
               end
            end

            S_COLLECT: begin
               if (asmComplete) begin
                  state_q     <= S_WRITE;
                  byteReady_q <= 1'b0;
                  we_q        <= 1'b1;
                  wa_q        <= ADDRESS_WIDTH'(wordIdx_q) << 2;
                  wd_q        <= MEM_WIDTH'(asmWord);
               end
            end

            S_WRITE: begin
               wordIdx_q <= wordIdx_q + NW_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_q    <= csum_q ^ WORD_BITS'(wd_q);
`endif
               if (wordIdx_q == numWords_q - NW_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_q     <= S_CHECK;
                  byteReady_q <= 1'b1;
`else
                  state_q     <= S_DONE;
                  done_q      <= 1'b1;
`endif
               end else begin
                  state_q     <= S_COLLECT;
                  byteReady_q <= 1'b1;
               end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            // The trailing word is compared, never written to memory.
            S_CHECK: begin
               if (asmComplete) begin
                  state_q     <= S_DONE;
                  byteReady_q <= 1'b0;
                  done_q      <= 1'b1;
                  err_q       <= (asmWord != csum_q);
               end
            end
`endif

            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q     <= S_IDLE;
               byteReady_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign byte_ready = byteReady_q;
   assign WE         = we_q;
   assign WA         = wa_q;
   assign WD         = wd_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
